// File: rtl/vai_rx_demux.sv
// CCI-P Rx demultiplexer for the nested virtual-AFU mux: routes c0/c1 upstream traffic to
// per-VM ports or the manager by mdata VMID or MMIO window, and captures control registers.
package vai_ccip_pkg;
  localparam int CCIP_MMIOADDR_WIDTH = 16;
  localparam int CCIP_MDATA_WIDTH    = 16;
  localparam int CCIP_CLDATA_WIDTH   = 512;

  typedef struct packed {
    logic [1:0]                  vc_used;
    logic                        hit_miss;
    logic [1:0]                  cl_num;
    logic [3:0]                  resp_type;
    logic [CCIP_MDATA_WIDTH-1:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [CCIP_MMIOADDR_WIDTH-1:0] address;
    logic [1:0]                     length;
    logic                           rsvd;
    logic [8:0]                     tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr           hdr;
    t_ccip_c0_ReqMmioHdr          mmio_hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
    logic                         rspValid;
    logic                         mmioRdValid;
    logic                         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [1:0]                  vc_used;
    logic                        hit_miss;
    logic                        format;
    logic [1:0]                  cl_num;
    logic [3:0]                  resp_type;
    logic [CCIP_MDATA_WIDTH-1:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module vai_rx_demux
  import vai_ccip_pkg::*;
#(
  parameter int                      NUM_SUB_AFUS    = 8,
  parameter int                      VMID_MSB        = 15,
  parameter int                      MMIO_WIN_LOG2   = 6,
  parameter int                      CTL_OFFSET_BASE = 3,
  parameter logic [NUM_SUB_AFUS-1:0] VM_ENABLE_RESET = '1,
  parameter int                      NUM_PIPE_STAGES = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  t_if_ccip_Rx             up_RxPort,
  output t_if_ccip_Rx             afu_RxPort [NUM_SUB_AFUS],
  output t_if_ccip_Rx             mgr_RxPort,
  output logic [63:0]             offset_array [NUM_SUB_AFUS],
  output logic [NUM_SUB_AFUS-1:0] vm_enable,
  output logic [31:0]             drop_cnt_c0,
  output logic [31:0]             drop_cnt_c1
);
  // Streams carry no backpressure: every asserted valid is consumed in the cycle it is
  // presented, one item per channel per cycle.
  localparam int VMID_WIDTH = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1;
  localparam int AW         = CCIP_MMIOADDR_WIDTH;
  localparam int WIN_W      = AW - MMIO_WIN_LOG2;
  localparam int IDX_W      = MMIO_WIN_LOG2 - 1;
  localparam logic [WIN_W:0] N_WIN = (WIN_W+1)'(NUM_SUB_AFUS);

  if ((2 ** (MMIO_WIN_LOG2 - 1)) <= (CTL_OFFSET_BASE + NUM_SUB_AFUS) ||
      (VMID_MSB + 1) < VMID_WIDTH || NUM_SUB_AFUS < 1 || NUM_SUB_AFUS > 64 ||
      NUM_PIPE_STAGES < 0 || NUM_PIPE_STAGES > 3) begin : g_param_check
    $error("vai_rx_demux: illegal parameter combination");
  end

  typedef struct packed {
    t_if_ccip_Rx           rx;
    logic [VMID_WIDTH-1:0] c0_vmid;
    logic                  c0_vmid_ok;
    logic [VMID_WIDTH-1:0] c1_vmid;
    logic                  c1_vmid_ok;
    logic [VMID_WIDTH-1:0] mmio_vmid;
    logic                  mmio_vmid_ok;
    logic                  is_ctl;
  } t_dec;

  typedef struct packed {
    t_if_ccip_c0_Rx          c0;
    logic [NUM_SUB_AFUS-1:0] c0_afu;
    logic                    c0_mgr;
    t_if_ccip_c1_Rx          c1;
    logic [NUM_SUB_AFUS-1:0] c1_afu;
  } t_route;

  function automatic logic vmid_ok(input logic [VMID_WIDTH-1:0] v);
    return {1'b0, v} < (VMID_WIDTH+1)'(NUM_SUB_AFUS);
  endfunction

  // 8B writes replace the register; 4B writes replace the half selected by address bit 0.
  function automatic logic [63:0] merge_wr(input logic [63:0] old, input logic [63:0] d,
                                           input logic [1:0] len, input logic hi);
    logic [63:0] r;
    r = old;
    if (len == 2'd1) r = d;
    else if (len == 2'd0) begin
      if (hi) r[63:32] = d[31:0];
      else    r[31:0]  = d[31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, c} + {31'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  t_if_ccip_Rx      s1;
  t_dec             dec, s2;
  t_route           rt, s3;
  t_route           pipe [NUM_PIPE_STAGES+1];
  logic [WIN_W-1:0] win;

  always_comb begin
    dec              = '0;
    dec.rx           = s1;
    win              = s1.c0.mmio_hdr.address[AW-1:MMIO_WIN_LOG2];
    dec.c0_vmid      = s1.c0.hdr.mdata[VMID_MSB -: VMID_WIDTH];
    dec.c0_vmid_ok   = vmid_ok(dec.c0_vmid);
    dec.c1_vmid      = s1.c1.hdr.mdata[VMID_MSB -: VMID_WIDTH];
    dec.c1_vmid_ok   = vmid_ok(dec.c1_vmid);
    dec.is_ctl       = (win == '0);
    dec.mmio_vmid    = VMID_WIDTH'(win - 1'b1);
    dec.mmio_vmid_ok = !dec.is_ctl && ({1'b0, win} <= N_WIN);
  end

  logic             mmio_v;
  logic [1:0]       drop_c0;
  logic [1:0]       drop_c1;
  logic             cap_en;
  logic [IDX_W-1:0] cap_idx;

  always_comb begin
    rt      = '0;
    drop_c0 = 2'd0;
    drop_c1 = 2'd0;
    cap_en  = 1'b0;
    cap_idx = s2.rx.c0.mmio_hdr.address[MMIO_WIN_LOG2-1:1];
    mmio_v  = s2.rx.c0.mmioRdValid | s2.rx.c0.mmioWrValid;
    if (s2.rx.c0.rspValid) begin
      if (s2.c0_vmid_ok && vm_enable[s2.c0_vmid]) begin
        rt.c0             = s2.rx.c0;
        rt.c0.mmioRdValid = 1'b0;
        rt.c0.mmioWrValid = 1'b0;
        rt.c0.hdr.mdata[VMID_MSB -: VMID_WIDTH] = '0;
        rt.c0_afu[s2.c0_vmid] = 1'b1;
      end else begin
        drop_c0 = 2'd1;
      end
      // A colliding MMIO loses to the response and is counted separately.
      if (mmio_v) drop_c0 = drop_c0 + 2'd1;
    end else if (mmio_v) begin
      if (s2.is_ctl) begin
        rt.c0     = s2.rx.c0;
        rt.c0_mgr = 1'b1;
        cap_en    = s2.rx.c0.mmioWrValid;
      end else if (s2.mmio_vmid_ok && vm_enable[s2.mmio_vmid]) begin
        rt.c0 = s2.rx.c0;
        rt.c0.mmio_hdr.address[AW-1:MMIO_WIN_LOG2] = '0;
        rt.c0_afu[s2.mmio_vmid] = 1'b1;
      end else if (s2.rx.c0.mmioRdValid) begin
        rt.c0     = s2.rx.c0;
        rt.c0_mgr = 1'b1;
      end else begin
        drop_c0 = 2'd1;
      end
    end
    if (s2.rx.c1.rspValid) begin
      if (s2.c1_vmid_ok && vm_enable[s2.c1_vmid]) begin
        rt.c1 = s2.rx.c1;
        rt.c1.hdr.mdata[VMID_MSB -: VMID_WIDTH] = '0;
        rt.c1_afu[s2.c1_vmid] = 1'b1;
      end else begin
        drop_c1 = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) offset_array[i] <= '0;
      vm_enable <= VM_ENABLE_RESET;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        if (cap_idx == IDX_W'(CTL_OFFSET_BASE + i))
          offset_array[i] <= merge_wr(offset_array[i], s2.rx.c0.data[63:0],
                                      s2.rx.c0.mmio_hdr.length, s2.rx.c0.mmio_hdr.address[0]);
      end
      if (cap_idx == IDX_W'(CTL_OFFSET_BASE + NUM_SUB_AFUS))
        vm_enable <= NUM_SUB_AFUS'(merge_wr(64'(vm_enable), s2.rx.c0.data[63:0],
                                            s2.rx.c0.mmio_hdr.length, s2.rx.c0.mmio_hdr.address[0]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      drop_cnt_c0 <= '0;
      drop_cnt_c1 <= '0;
      for (int k = 0; k <= NUM_PIPE_STAGES; k++) pipe[k] <= '0;
    end else begin
      s1          <= up_RxPort;
      s2          <= dec;
      s3          <= rt;
      drop_cnt_c0 <= sat_add(drop_cnt_c0, drop_c0);
      drop_cnt_c1 <= sat_add(drop_cnt_c1, drop_c1);
      pipe[0]     <= s3;
      for (int k = 1; k <= NUM_PIPE_STAGES; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_comb begin
    mgr_RxPort    = '0;
    mgr_RxPort.c0 = pipe[NUM_PIPE_STAGES].c0_mgr ? pipe[NUM_PIPE_STAGES].c0 : '0;
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      afu_RxPort[i]    = '0;
      afu_RxPort[i].c0 = pipe[NUM_PIPE_STAGES].c0_afu[i] ? pipe[NUM_PIPE_STAGES].c0 : '0;
      afu_RxPort[i].c1 = pipe[NUM_PIPE_STAGES].c1_afu[i] ? pipe[NUM_PIPE_STAGES].c1 : '0;
    end
  end
endmodule

// File: tb/tb_vai_rx_demux.sv
// Randomised bench for vai_rx_demux: a per-item reference model predicts every output port
// each cycle, plus directed sequences for the documented scenarios and a mid-stream reset.
module tb_vai_rx_demux;
  import vai_ccip_pkg::*;

  localparam int N        = 8;
  localparam int VW       = 3;
  localparam int VMID_MSB = 15;
  localparam int WL       = 6;
  localparam int BASE     = 3;
  localparam int P        = 2;
  localparam int LAT      = 4 + P;
  localparam int SH       = VMID_MSB - VW + 1;
  localparam int RX_W     = $bits(t_if_ccip_Rx);
  localparam int CW       = 640;
  localparam int SB_W     = (N + 1) * RX_W;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  t_if_ccip_Rx up_rx;
  t_if_ccip_Rx afu_rx [N];
  t_if_ccip_Rx mgr_rx;
  logic [63:0] offs [N];
  logic [N-1:0] vm_en;
  logic [31:0] d0, d1;

  vai_rx_demux #(
    .NUM_SUB_AFUS(N), .VMID_MSB(VMID_MSB), .MMIO_WIN_LOG2(WL), .CTL_OFFSET_BASE(BASE),
    .VM_ENABLE_RESET(8'hFF), .NUM_PIPE_STAGES(P)
  ) dut (
    .clk(clk), .reset_n(reset_n), .up_RxPort(up_rx), .afu_RxPort(afu_rx),
    .mgr_RxPort(mgr_rx), .offset_array(offs), .vm_enable(vm_en),
    .drop_cnt_c0(d0), .drop_cnt_c1(d1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [N-1:0]    m_en;
  logic [63:0]     m_off [N];
  longint          m_d0, m_d1;

  task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = '1;
    foreach (m_off[i]) m_off[i] = '0;
    m_d0 = 0;
    m_d1 = 0;
  endtask

  function automatic logic [63:0] apply_wr(input logic [63:0] old, input logic [63:0] d,
                                           input int len, input int hi);
    logic [63:0] r;
    r = old;
    if (len == 1) r = d;
    else if (len == 0 && hi == 1) r = {d[31:0], old[31:0]};
    else if (len == 0) r = {old[63:32], d[31:0]};
    return r;
  endfunction

  // Items are judged in arrival order: each sees every control write that came before it.
  task automatic model_step(input t_if_ccip_Rx it);
    t_if_ccip_Rx     e [N+1];
    logic [SB_W-1:0] v;
    int vm, vm1, win, lo, idx;
    bit mmio;
    foreach (e[i]) e[i] = '0;
    vm   = (int'(it.c0.hdr.mdata) / (2 ** SH)) % (2 ** VW);
    vm1  = (int'(it.c1.hdr.mdata) / (2 ** SH)) % (2 ** VW);
    win  = int'(it.c0.mmio_hdr.address) / (2 ** WL);
    lo   = int'(it.c0.mmio_hdr.address) % (2 ** WL);
    mmio = it.c0.mmioRdValid || it.c0.mmioWrValid;
    if (it.c0.rspValid) begin
      if (vm < N && m_en[vm]) begin
        e[vm].c0 = it.c0;
        e[vm].c0.mmioRdValid = 1'b0;
        e[vm].c0.mmioWrValid = 1'b0;
        e[vm].c0.hdr.mdata = 16'(int'(it.c0.hdr.mdata) - vm * (2 ** SH));
      end else m_d0++;
      if (mmio) m_d0++;
    end else if (mmio) begin
      if (win == 0) begin
        e[N].c0 = it.c0;
        if (it.c0.mmioWrValid) begin
          idx = lo / 2;
          if (idx >= BASE && idx < BASE + N)
            m_off[idx-BASE] = apply_wr(m_off[idx-BASE], it.c0.data[63:0],
                                       int'(it.c0.mmio_hdr.length), lo % 2);
          else if (idx == BASE + N)
            m_en = N'(apply_wr(64'(m_en), it.c0.data[63:0], int'(it.c0.mmio_hdr.length), lo % 2));
        end
      end else if (win - 1 < N && m_en[win-1]) begin
        e[win-1].c0 = it.c0;
        e[win-1].c0.mmio_hdr.address = 16'(lo);
      end else if (it.c0.mmioRdValid) e[N].c0 = it.c0;
      else m_d0++;
    end
    if (it.c1.rspValid) begin
      if (vm1 < N && m_en[vm1]) begin
        e[vm1].c1 = it.c1;
        e[vm1].c1.hdr.mdata = 16'(int'(it.c1.hdr.mdata) - vm1 * (2 ** SH));
      end else m_d1++;
    end
    for (int i = 0; i <= N; i++) v[i*RX_W +: RX_W] = e[i];
    exp_q.push_back(v);
  endtask

  task automatic cycle(input t_if_ccip_Rx it);
    logic [SB_W-1:0] e;
    @(posedge clk);
    #1 up_rx = it;
    model_step(it);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", CW'(0), CW'(1));
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < N; i++)
        check_eq($sformatf("afu%0d", i), CW'(afu_rx[i]), CW'(e[i*RX_W +: RX_W]));
      check_eq("mgr", CW'(mgr_rx), CW'(e[N*RX_W +: RX_W]));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < N; i++) check_eq($sformatf("%s_off%0d", tag, i), CW'(offs[i]), CW'(m_off[i]));
    check_eq({tag, "_vm_enable"}, CW'(vm_en), CW'(m_en));
    check_eq({tag, "_drop_c0"}, CW'(d0), CW'(m_d0));
    check_eq({tag, "_drop_c1"}, CW'(d1), CW'(m_d1));
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_afu%0d", tag, i), CW'(afu_rx[i]), CW'(0));
      check_eq($sformatf("%s_off%0d", tag, i), CW'(offs[i]), CW'(0));
    end
    check_eq({tag, "_mgr"}, CW'(mgr_rx), CW'(0));
    check_eq({tag, "_vm_enable"}, CW'(vm_en), CW'(8'hFF));
    check_eq({tag, "_drop_c0"}, CW'(d0), CW'(0));
    check_eq({tag, "_drop_c1"}, CW'(d1), CW'(0));
  endtask

  function automatic t_if_ccip_Rx mk_rsp0(input logic [15:0] md);
    t_if_ccip_Rx it;
    it = '0;
    it.c0.rspValid = 1'b1;
    it.c0.hdr.mdata = md;
    it.c0.hdr.resp_type = 4'($urandom);
    for (int i = 0; i < 16; i++) it.c0.data[i*32 +: 32] = $urandom;
    return it;
  endfunction

  function automatic t_if_ccip_Rx mk_mmio(input bit wr, input logic [15:0] addr,
                                          input logic [1:0] len, input logic [63:0] d);
    t_if_ccip_Rx it;
    it = '0;
    it.c0.mmioWrValid = wr;
    it.c0.mmioRdValid = !wr;
    it.c0.mmio_hdr.address = addr;
    it.c0.mmio_hdr.length = len;
    it.c0.mmio_hdr.tid = 9'($urandom);
    it.c0.data[63:0] = d;
    return it;
  endfunction

  function automatic t_if_ccip_Rx rand_item();
    t_if_ccip_Rx it, m;
    int r;
    logic [15:0] a;
    r = $urandom_range(0, 9);
    a = 16'($urandom_range(0, 10) * 64 + $urandom_range(0, 63));
    m = mk_mmio(r inside {5, 6}, a, 2'($urandom_range(0, 1)), {$urandom, $urandom});
    it = '0;
    if (r <= 2) it = mk_rsp0(16'($urandom));
    else if (r <= 6) it = m;
    else if (r == 7) begin
      it = mk_rsp0(16'($urandom));
      it.c0.mmio_hdr = m.c0.mmio_hdr;
      it.c0.mmioRdValid = m.c0.mmioRdValid;
      it.c0.mmioWrValid = m.c0.mmioWrValid;
    end
    if ($urandom_range(0, 1) == 1) begin
      it.c1.rspValid = 1'b1;
      it.c1.hdr.mdata = 16'($urandom);
      it.c1.hdr.cl_num = 2'($urandom);
    end
    return it;
  endfunction

  initial begin
    t_if_ccip_Rx it;
    up_rx = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    repeat (LAT) exp_q.push_back('0);

    // Response routing with VMID stripping.
    cycle(mk_rsp0(16'h3ABC));
    idle(LAT);
    check_eq("t1_valid", CW'(afu_rx[1].c0.rspValid), CW'(1));
    check_eq("t1_mdata", CW'(afu_rx[1].c0.hdr.mdata), CW'(16'h1ABC));

    // Enable-mask write, then a c1 response to a now-disabled VM.
    cycle(mk_mmio(1'b1, 16'h0016, 2'd1, 64'hFD));
    idle(LAT);
    check_eq("t2_vm_enable", CW'(vm_en), CW'(8'hFD));
    cycle('0);
    it = '0;
    it.c1.rspValid = 1'b1;
    it.c1.hdr.mdata = 16'h2001;
    cycle(it);
    idle(LAT);
    check_eq("t2_drop_c1", CW'(d1), CW'(1));

    // Two 4B halves into offset_array[0].
    cycle(mk_mmio(1'b1, 16'h0006, 2'd0, 64'h1234));
    cycle(mk_mmio(1'b1, 16'h0007, 2'd0, 64'h5678));
    idle(LAT);
    check_eq("t3_offset0", CW'(offs[0]), CW'(64'h0000_5678_0000_1234));

    // Orphan read goes to the manager; once enabled, the VM sees the window-relative address.
    cycle(mk_mmio(1'b0, 16'h0085, 2'd0, 64'h0));
    idle(LAT);
    check_eq("t4_mgr_rd", CW'(mgr_rx.c0.mmioRdValid), CW'(1));
    check_eq("t4_mgr_addr", CW'(mgr_rx.c0.mmio_hdr.address), CW'(16'h0085));
    check_eq("t4_drop_c0", CW'(d0), CW'(0));
    cycle(mk_mmio(1'b1, 16'h0016, 2'd1, 64'hFF));
    cycle(mk_mmio(1'b0, 16'h0085, 2'd0, 64'h0));
    idle(LAT);
    check_eq("t4_afu_rd", CW'(afu_rx[1].c0.mmioRdValid), CW'(1));
    check_eq("t4_afu_addr", CW'(afu_rx[1].c0.mmio_hdr.address), CW'(16'h0005));

    // Full-rate back-to-back traffic on both channels.
    for (int k = 0; k < 10; k++) begin
      it = mk_rsp0(16'h4000 | 16'(k));
      it.c1.rspValid = 1'b1;
      it.c1.hdr.mdata = 16'hA000 | 16'(k);
      cycle(it);
    end
    idle(LAT);
    check_regs("t5");

    for (int b = 0; b < 20; b++) begin
      repeat (20) cycle(rand_item());
      idle(LAT);
      check_regs("rand");
    end

    // Reset with items in flight.
    cycle(mk_mmio(1'b1, 16'h0016, 2'd1, 64'hFF));
    for (int k = 0; k < 4; k++) begin
      it = mk_rsp0(16'h4111);
      it.c1.rspValid = 1'b1;
      it.c1.hdr.mdata = 16'hA222;
      cycle(it);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    up_rx = '0;
    #1 check_reset_state("t6_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    exp_q.delete();
    repeat (LAT) exp_q.push_back('0);
    idle(LAT + 10);
    check_regs("t6_post");
    repeat (30) cycle(rand_item());
    idle(LAT);
    check_regs("t6_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vai_rx_demux.md
Name: vai_rx_demux

Overview:
- Parametrised next-generation CCI-P Rx demultiplexer for the nested virtual-AFU mux.
- Splits the upstream Rx stream (c0 memory responses, c0 MMIO requests, c1 write responses) into per-sub-AFU Rx ports plus a manager port. The split uses the VMID carried in the mdata top bits or the MMIO address window.
- Adds over the previous generation: configurable VMID position and MMIO window size, per-VM enable mask, control-register capture with 4B/8B write support, redirection of orphan MMIO reads to the manager, saturating drop counters, and configurable output pipelining.

Parameters:
NUM_SUB_AFUS, 8, number of downstream sub-AFUs (1..64); VMID_WIDTH = max(1, $clog2(NUM_SUB_AFUS))
VMID_MSB, 15, mdata bit holding the VMID MSB; VMID occupies mdata[VMID_MSB -: VMID_WIDTH]
MMIO_WIN_LOG2, 6, per-VM MMIO window size in log2 of 4B address units
CTL_OFFSET_BASE, 3, 64-bit control register index of offset_array[0]
VM_ENABLE_RESET, all ones, reset value of the vm_enable mask
NUM_PIPE_STAGES, 0, extra output register stages (0..3)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
up_RxPort  in  t_if_ccip_Rx  upstream Rx
afu_RxPort[NUM_SUB_AFUS]  out  t_if_ccip_Rx  per-sub-AFU Rx
mgr_RxPort  out  t_if_ccip_Rx  manager Rx; c1 is always 0
offset_array[NUM_SUB_AFUS]  out  64 each  per-VM address offsets
vm_enable  out  NUM_SUB_AFUS  per-VM enable mask
drop_cnt_c0  out  32  saturating count of dropped c0 items
drop_cnt_c1  out  32  saturating count of dropped c1 responses

Behaviour:
- Reset: clk and reset_n only; reset is asynchronous assert, synchronous deassert via a 2-flop synchroniser.
  - While in reset: all pipeline registers and afu_RxPort/mgr_RxPort are 0, offset_array is 0, vm_enable = VM_ENABLE_RESET, counters are 0.
  - Reset mid-stream discards all in-flight items; none appear after deassertion.
- Pipeline: T1 register input; T2 decode; T3 route/rewrite plus control capture; T4 output register; then NUM_PIPE_STAGES extra stages. Latency from up_RxPort to output is 4+NUM_PIPE_STAGES cycles. Throughput is 1 item per channel per cycle; there is no backpressure.
- Window decode uses win = address[CCIP_MMIOADDR_WIDTH-1:MMIO_WIN_LOG2].
  - win==0 is the control window.
  - Otherwise mmio_vmid = win-1.
- c0 routing, in priority order:
  1. rspValid: vmid = mdata VMID field. If vmid < NUM_SUB_AFUS and vm_enable[vmid], deliver to afu_RxPort[vmid].c0 with the VMID field zeroed and other fields unchanged. Otherwise drop and increment drop_cnt_c0. If rspValid and an mmio valid occur together, rspValid wins; the MMIO is dropped and counted.
  2. MMIO in a VM window, VM valid and enabled: deliver to afu_RxPort[mmio_vmid].c0 with address upper bits [CCIP_MMIOADDR_WIDTH-1:MMIO_WIN_LOG2] zeroed; data, length and tid are unchanged.
  3. MMIO in a VM window, VM invalid or disabled:
     - mmioRd is forwarded to mgr_RxPort.c0 with the original address, so the host read still completes.
     - mmioWr is dropped and counted.
  4. MMIO in the control window: forward unchanged to mgr_RxPort.c0.
- Control capture (mmioWrValid in the control window, committed at T3): idx = address[MMIO_WIN_LOG2-1:1].
  - idx in [CTL_OFFSET_BASE, CTL_OFFSET_BASE+NUM_SUB_AFUS) writes offset_array[idx-CTL_OFFSET_BASE].
  - idx == CTL_OFFSET_BASE+NUM_SUB_AFUS writes vm_enable from data[NUM_SUB_AFUS-1:0].
  - Length 8B updates all 64 bits. Length 4B updates bits [31:0] if address[0]==0, else [63:32].
  - Other idx values: no capture.
- Enable timing: a mask change affects items reaching T3 on the cycle after the capture edge. An item in T3 on the same edge sees the old mask.
- c1 routing: rspValid with a valid, enabled VMID goes to afu_RxPort[vmid].c1 with the VMID field zeroed. Otherwise it is dropped and increments drop_cnt_c1.
- Counters: a c0 drop and a c1 drop in the same cycle each increment their own counter. Counters hold at 0xFFFF_FFFF.
- Outputs: non-selected ports carry all-zero for that cycle. Exactly one destination is valid per item.
- Elaboration: assert 2^(MMIO_WIN_LOG2-1) > CTL_OFFSET_BASE+NUM_SUB_AFUS and VMID_MSB+1 >= VMID_WIDTH.

Test Plan:
1. Reset, then c0 rspValid with mdata=0x3ABC (defaults, VMID_WIDTH=3) → afu_RxPort[1].c0 rspValid with mdata=0x1ABC at cycle +4; all other ports zero.
2. 8B mmioWr at address 0x16 (idx 11), data=0xFD → vm_enable=0xFD. Then c1 rsp with mdata=0x2001 → not delivered, drop_cnt_c1=1.
3. 4B mmioWr at address 0x06 data=0x1234, then at address 0x07 data=0x5678 → offset_array[0]=0x0000_5678_0000_1234.
4. mmioRd at address 0x0085 while vm_enable[1]=0 → forwarded on mgr_RxPort.c0 with address 0x0085, drop_cnt_c0 unchanged. The same access with vm_enable[1]=1 → afu_RxPort[1].c0 receives address 0x0005.
5. c0 rspValid (VMID 2) and c1 rsp (VMID 5) back-to-back for 10 cycles with NUM_PIPE_STAGES=2 → each arrives at cycle +6 on its own port, one item per cycle, no loss.
6. Deassert reset_n with items in T2/T3 → all outputs zero immediately (asynchronous), offset_array=0, vm_enable=0xFF, counters=0, and no stale item after reset release.
